fifo_flow_thresh: RTL and testbench

- Synchronous FIFO with programmable almost-full/almost-empty thresholds. One instance per buffer stage: main, VC0, VC1, D0, D1.
- Consumes the low/high threshold pair that the control FSM drives during init.
- Produces the per-FIFO empty and error bits that the control FSM collects into its empties/errors vectors.
- Also produces the pause/almost_empty flow-control signals used by neighbouring stages.

---
 rtl/fifo_flow_thresh_pkg.sv | 19 +
 rtl/fifo_flow_thresh_if.sv | 36 +++
 rtl/fifo_flow_thresh_mem_2p.sv | 40 ++++
 rtl/fifo_flow_thresh.sv | 112 +++++++++++
 tb/tb_fifo_flow_thresh.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fifo_flow_thresh_pkg.sv
// Purpose : shared widths and per-stage indices for the threshold FIFOs.
// Latency : n/a (constants only).
// Backpressure: n/a.
// Index constants pick each stage's bit in the controller's empties/errors vectors.
package fifo_flow_thresh_pkg;

   localparam int DEF_DATA_W = 6;   // 2-bit class + 4-bit payload
   localparam int DEF_ADDR_W = 4;   // 16 words
   localparam int DEF_CNT_W  = 5;   // occupancy 0..16 needs one extra bit

   // Bit positions of each buffer stage in the empties/errors vectors.
   localparam int FIFO_MAIN = 0;
   localparam int FIFO_VC0  = 1;
   localparam int FIFO_VC1  = 2;
   localparam int FIFO_D0   = 3;
   localparam int FIFO_D1   = 4;
   localparam int FIFO_NUM  = 5;

endpackage

// File: rtl/fifo_flow_thresh_if.sv
// Purpose : push/pop, threshold-load and status bundle for one threshold FIFO.
// Latency : n/a (wiring only).
// Backpressure: full/pause flow from slave to master.
// master: drives init/thr_low/thr_high/wr_en/data_in/rd_en, observes status.
// slave : the FIFO; drives data_out/valid_out/count and the four flags plus error.
interface fifo_flow_thresh_if
   import fifo_flow_thresh_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
);
   logic              init;
   logic [CNT_W-1:0]  thr_low;
   logic [CNT_W-1:0]  thr_high;
   logic              wr_en;
   logic [DATA_W-1:0] data_in;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              almost_empty;
   logic              pause;
   logic              error;

   modport master (
      output init, thr_low, thr_high, wr_en, data_in, rd_en,
      input  data_out, valid_out, count, empty, full, almost_empty, pause, error
   );

   modport slave (
      input  init, thr_low, thr_high, wr_en, data_in, rd_en,
      output data_out, valid_out, count, empty, full, almost_empty, pause, error
   );
endinterface

// File: rtl/fifo_flow_thresh_mem_2p.sv
// Purpose : DEPTH x DATA_W two-port register array, sync write, registered read.
// Latency : read data valid one cycle after rd_en; writes visible next cycle.
// Backpressure: none; the caller guarantees legal addresses and enables.
// Ports: clk/rst, write port (wr_en, wr_addr, wr_dat), read port (rd_en, rd_addr, rd_dat).
// Read register holds its value while rd_en is low; only it is reset, not the array.
module fifo_mem_2p
   import fifo_flow_thresh_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   // Same-address read and write in one cycle returns the old word, which is
   // what a full FIFO doing push+pop needs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dat <= '0;
      end else if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_flow_thresh.sv
// Purpose : synchronous FIFO with programmable almost-empty / almost-full thresholds.
// Latency : 1 cycle rd_en -> data_out/valid_out; no push-to-pop bypass.
// Backpressure: pause when count >= thr_high; push while full is dropped unless popping.
// Ports: clk, reset (sync, active-high), bus (slave modport of fifo_flow_thresh_if).
// Status flags are registered from the next occupancy so they always match count.
// error is sticky (overflow or underflow) until reset.
module fifo_flow_thresh
   import fifo_flow_thresh_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   fifo_flow_thresh_if.slave bus
);

   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**ADDR_W);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  lo_q;
   logic [CNT_W-1:0]  hi_q;
   logic [CNT_W-1:0]  lo_nxt;
   logic [CNT_W-1:0]  hi_nxt;
   logic              empty_q;
   logic              full_q;
   logic              ae_q;
   logic              pause_q;
   logic              valid_q;
   logic              err_q;
   logic              push;
   logic              pop;
   logic              ovf;
   logic              udf;
   logic [DATA_W-1:0] rd_dat;

   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign push = bus.wr_en & (~full_q | bus.rd_en);
   assign pop  = bus.rd_en & ~empty_q;
   assign ovf  = bus.wr_en & full_q & ~bus.rd_en;
   assign udf  = bus.rd_en & empty_q;

   always_comb begin
      cnt_nxt = count_q;
      case ({push, pop})
         2'b10:   cnt_nxt = count_q + CNT_W'(1);
         2'b01:   cnt_nxt = count_q - CNT_W'(1);
         default: cnt_nxt = count_q;
      endcase
      // Flags registered this cycle must reflect the thresholds that will be
      // held next cycle, so a load is seen together with the new count.
      lo_nxt = bus.init ? bus.thr_low  : lo_q;
      hi_nxt = bus.init ? bus.thr_high : hi_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         lo_q    <= '0;
         hi_q    <= DEPTH;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         pause_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow.
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         count_q <= cnt_nxt;
         lo_q    <= lo_nxt;
         hi_q    <= hi_nxt;
         empty_q <= (cnt_nxt == '0);
         full_q  <= (cnt_nxt == DEPTH);
         ae_q    <= (cnt_nxt <= lo_nxt);
         pause_q <= (cnt_nxt >= hi_nxt);
         valid_q <= pop;
         if (ovf | udf) err_q <= 1'b1;
      end
   end

   fifo_mem_2p #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (reset),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_dat  (bus.data_in),
      .rd_en   (pop),
      .rd_addr (rd_ptr),
      .rd_dat  (rd_dat)
   );

   assign bus.data_out     = rd_dat;
   assign bus.valid_out    = valid_q;
   assign bus.count        = count_q;
   assign bus.empty        = empty_q;
   assign bus.full         = full_q;
   assign bus.almost_empty = ae_q;
   assign bus.pause        = pause_q;
   assign bus.error        = err_q;

endmodule

// File: tb/tb_fifo_flow_thresh.sv
// Purpose : self-checking bench for fifo_flow_thresh with a queue scoreboard.
// Latency : expects popped words one cycle after the edge that accepted rd_en.
// Backpressure: reference model decides push/pop/overflow from its own occupancy.
module tb_fifo_flow_thresh;

   logic clk = 1'b0;
   logic reset;

   fifo_flow_thresh_if bus ();

   fifo_flow_thresh dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: stored words, words awaiting output, thresholds, sticky error.
   int mq[$];
   int exp_q[$];
   int m_lo, m_hi, m_dout;
   bit m_err, m_v;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   task automatic model_edge(input bit rst, input bit ini, input int tl, input int th,
                             input bit wr, input int din, input bit rd);
      bit m_full, m_empty, m_push, m_pop;
      if (rst) begin
         mq.delete();
         exp_q.delete();
         m_lo = 0; m_hi = 16; m_err = 0; m_v = 0; m_dout = 0;
      end else begin
         m_full  = (mq.size() == 16);
         m_empty = (mq.size() == 0);
         m_push  = wr && (!m_full || rd);
         m_pop   = rd && !m_empty;
         if ((wr && m_full && !rd) || (rd && m_empty)) m_err = 1;
         m_v = m_pop;
         if (m_pop) exp_q.push_back(mq.pop_front());
         if (m_push) mq.push_back(din & 6'h3f);
         if (ini) begin
            m_lo = tl;
            m_hi = th;
         end
      end
   endtask

   task automatic check_outputs();
      int n;
      n = mq.size();
      check("count",        int'(bus.count),        n);
      check("empty",        int'(bus.empty),        int'(n == 0));
      check("full",         int'(bus.full),         int'(n == 16));
      check("almost_empty", int'(bus.almost_empty), int'(n <= m_lo));
      check("pause",        int'(bus.pause),        int'(n >= m_hi));
      check("error",        int'(bus.error),        int'(m_err));
      check("valid_out",    int'(bus.valid_out),    int'(m_v));
      if (m_v && exp_q.size() > 0) m_dout = exp_q.pop_front();
      check(m_v ? "data_out" : "data_hold", int'(bus.data_out), m_dout);
   endtask

   task automatic step(input bit rst, input bit ini, input int tl, input int th,
                       input bit wr, input int din, input bit rd);
      reset        = rst;
      bus.init     = ini;
      bus.thr_low  = 5'(tl);
      bus.thr_high = 5'(th);
      bus.wr_en    = wr;
      bus.data_in  = 6'(din);
      bus.rd_en    = rd;
      @(posedge clk);
      model_edge(rst, ini, tl, th, wr, din, rd);
      #1;
      check_outputs();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.init = 0; bus.thr_low = '0; bus.thr_high = '0;
      bus.wr_en = 0; bus.data_in = '0; bus.rd_en = 0;

      // Reset and threshold load 3/6.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check("rst_data_out", int'(bus.data_out), 0);
      step(0, 1, 3, 6, 0, 0, 0);
      check("init_ae", int'(bus.almost_empty), 1);
      check("init_pause", int'(bus.pause), 0);

      // Push 1..6: almost_empty drops at 4, pause rises at 6.
      for (int i = 1; i <= 6; i++) begin
         step(0, 0, 0, 0, 1, i, 0);
         if (i == 3) check("ae_at3", int'(bus.almost_empty), 1);
         if (i == 4) check("ae_at4", int'(bus.almost_empty), 0);
         if (i == 5) check("pause_at5", int'(bus.pause), 0);
         if (i == 6) check("pause_at6", int'(bus.pause), 1);
      end
      for (int i = 7; i <= 16; i++) step(0, 0, 0, 0, 1, i, 0);
      check("full_at16", int'(bus.full), 1);

      // Overflow: word dropped, error sticks.
      step(0, 0, 0, 0, 1, 6'h3f, 0);
      check("ovf_count", int'(bus.count), 16);
      check("ovf_error", int'(bus.error), 1);

      // Drain 16 in order.
      for (int i = 1; i <= 16; i++) step(0, 0, 0, 0, 0, 0, 1);
      idle();
      check("drained_empty", int'(bus.empty), 1);

      // Fresh start, fill, then push+pop at full for 4 cycles.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 6, 0, 0, 0);
      for (int i = 1; i <= 16; i++) step(0, 0, 0, 0, 1, i, 0);
      for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1, 6'h20 + i, 1);
      check("full_rw_count", int'(bus.count), 16);
      check("full_rw_error", int'(bus.error), 0);
      for (int i = 1; i <= 16; i++) step(0, 0, 0, 0, 0, 0, 1);

      // Underflow at empty, then push+pop at empty.
      step(0, 0, 0, 0, 0, 0, 1);
      check("udf_valid", int'(bus.valid_out), 0);
      check("udf_error", int'(bus.error), 1);
      step(0, 0, 0, 0, 1, 6'h2a, 1);
      check("empty_rw_count", int'(bus.count), 1);
      check("empty_rw_valid", int'(bus.valid_out), 0);

      // Reach count 9, reset mid-stream.
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 6'h30 + i, 0);
      check("pre_rst_count", int'(bus.count), 9);
      step(1, 0, 0, 0, 0, 0, 0);
      check("mid_rst_count", int'(bus.count), 0);
      check("mid_rst_error", int'(bus.error), 0);
      check("mid_rst_ae", int'(bus.almost_empty), 1);
      check("mid_rst_pause", int'(bus.pause), 0);

      // Inverted thresholds 10/7: both flags high at count 8.
      step(0, 1, 10, 7, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 6'h10 + i, 0);
      check("inv_ae_at8", int'(bus.almost_empty), 1);
      check("inv_pause_at8", int'(bus.pause), 1);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1);

      // Zero almost-full threshold keeps pause high even when empty.
      step(0, 1, 0, 0, 0, 0, 0);
      check("thr0_pause", int'(bus.pause), 1);

      // Random mixed traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step(0, ($urandom_range(0, 19) == 0), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1));
      end
      for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 0, 1);
      idle();
      check("sb_leftover", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
